// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and helper functions for the message-schedule stage.
package sha256_pkg;

  localparam int ROUNDS          = 64;
  localparam int WORDS_PER_BLOCK = 16;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  function automatic word_t right_rotate(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return right_rotate(x, 7) ^ right_rotate(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return right_rotate(x, 17) ^ right_rotate(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// Combinational next-word generator for the 16-word schedule window:
// W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32.
module sha256_sched_word
  import sha256_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [31:0] w9_i,
  input  logic [31:0] w14_i,
  output logic [31:0] w_next_o
);

  // Carries out of bit 31 are dropped by the 32-bit result width.
  assign w_next_o = small_sigma1(w14_i) + w9_i + small_sigma0(w1_i) + w0_i;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block and streams W[0..63]
// with round index over a valid/ready interface, using a sliding 16-word window.
module sha256_msg_schedule #(
  parameter int BLOCK_W = 512,
  parameter int WORD_W  = 32,
  parameter int ROUNDS  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               block_valid,
  output logic               block_ready,
  input  logic [BLOCK_W-1:0] block_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  w_out,
  output logic [5:0]         round_index,
  output logic               out_last
);

  import sha256_pkg::*;

  localparam int CNT_W = $clog2(ROUNDS);

  sched_state_t      state_q, state_d;
  logic [WORD_W-1:0] win_q [WORDS_PER_BLOCK];
  logic [WORD_W-1:0] win_d [WORDS_PER_BLOCK];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] next_word;
  logic              beat;
  logic              load;
  logic              last;

  sha256_sched_word u_sched_word (
    .w0_i     (win_q[0]),
    .w1_i     (win_q[1]),
    .w9_i     (win_q[9]),
    .w14_i    (win_q[14]),
    .w_next_o (next_word)
  );

  assign block_ready = (state_q == IDLE);
  assign out_valid   = (state_q == RUN);
  assign beat        = out_valid & out_ready;
  assign load        = block_valid & block_ready;
  assign last        = (cnt_q == CNT_W'(ROUNDS - 1));

  assign w_out       = out_valid ? win_q[0] : '0;
  assign round_index = 6'(cnt_q);
  assign out_last    = out_valid & last;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;

    // flush wins over a simultaneous beat or load; window contents are left as-is.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
              win_d[i] = block_data[BLOCK_W-1-WORD_W*i -: WORD_W];
            end
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (beat) begin
            for (int i = 0; i < WORDS_PER_BLOCK - 1; i++) begin
              win_d[i] = win_q[i+1];
            end
            win_d[WORDS_PER_BLOCK-1] = next_word;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: the window is reset as well so w_out and all later window-derived words are deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a full-array SHA-256 schedule model.
module tb_sha256_msg_schedule;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  w_out;
  logic [5:0]   round_index;
  logic         out_last;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  sha256_msg_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_data  (block_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .w_out       (w_out),
    .round_index (round_index),
    .out_last    (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook 64-entry schedule expansion.
  task automatic compute_expected(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
    return r;
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge where W[0] is shown.
  task automatic load_block(input logic [511:0] blk);
    compute_expected(blk);
    block_valid = 1'b1;
    block_data  = blk;
    n_checks++;
    if (block_ready !== 1'b1) $display("FAIL load_ready: got %b exp 1", block_ready);
    else n_pass++;
    @(negedge clk);
    block_valid = 1'b0;
  endtask

  // Walks the output stream; stops at index stop_at (before beating it) or after all 64 beats.
  task automatic consume(input int stop_at, input int ready_pct, input bit hold_bv,
                         input logic [511:0] other, output int cycles);
    int  idx;
    bit  rdy;
    bit  timeout;
    logic [40:0] got_v, exp_v;
    idx = 0; cycles = 0; timeout = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      got_v = {out_valid, block_ready, out_last, round_index, w_out};
      exp_v = {1'b1, 1'b0, (idx == 63), 6'(idx), exp_w[idx]};
      n_checks++;
      if (got_v !== exp_v)
        $display("FAIL word[%0d]: got v=%b rdy=%b last=%b idx=%0d w=%h exp v=%b rdy=%b last=%b idx=%0d w=%h",
                 idx, got_v[40], got_v[39], got_v[38], got_v[37:32], got_v[31:0],
                 exp_v[40], exp_v[39], exp_v[38], exp_v[37:32], exp_v[31:0]);
      else n_pass++;
      if (idx == stop_at) begin
        timeout = 1'b0;
        break;
      end
      rdy = ($urandom_range(99) < ready_pct);
      out_ready = rdy;
      if (hold_bv) begin
        block_valid = 1'b1;
        block_data  = other;
      end
      if (rdy) begin
        got_w[idx] = w_out;
        idx++;
      end
      @(negedge clk);
      cycles++;
      if (idx == 64) begin
        timeout = 1'b0;
        break;
      end
    end
    n_checks++;
    if (timeout) $display("FAIL consume_timeout: got idx %0d exp %0d", idx, stop_at);
    else n_pass++;
    if (idx == 64) begin
      got_v = {out_valid, block_ready, out_last, round_index, 32'h0};
      exp_v = {1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
      n_checks++;
      if (got_v[40:32] !== exp_v[40:32])
        $display("FAIL idle_after_block: got v/rdy/last/idx=%b exp %b", got_v[40:32], exp_v[40:32]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; block_valid = 1'b0; out_ready = 1'b0; block_data = '0;
    #12;
    n_checks++;
    if ({out_valid, block_ready, out_last, round_index, w_out} !== {1'b0, 1'b1, 1'b0, 6'd0, 32'd0})
      $display("FAIL reset_values: got v=%b rdy=%b last=%b idx=%0d w=%h exp 0 1 0 0 00000000",
               out_valid, block_ready, out_last, round_index, w_out);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, block_ready} !== 2'b01)
      $display("FAIL idle_after_reset: got v/rdy=%b exp 01", {out_valid, block_ready});
    else n_pass++;
  endtask

  task automatic test_abc();
    logic [511:0] abc;
    int cyc;
    abc = {32'h61626380, 448'h0, 32'h00000018};
    load_block(abc);
    consume(64, 100, 1'b0, '0, cyc);
    n_checks++;
    if (got_w[0] !== 32'h61626380) $display("FAIL abc_w0: got %h exp 61626380", got_w[0]);
    else n_pass++;
    n_checks++;
    if (got_w[15] !== 32'h00000018) $display("FAIL abc_w15: got %h exp 00000018", got_w[15]);
    else n_pass++;
    n_checks++;
    if (got_w[16] !== 32'h61626380) $display("FAIL abc_w16: got %h exp 61626380", got_w[16]);
    else n_pass++;
    n_checks++;
    if (got_w[17] !== 32'h000F0000) $display("FAIL abc_w17: got %h exp 000f0000", got_w[17]);
    else n_pass++;
    n_checks++;
    if (cyc !== 64) $display("FAIL abc_cycles: got %0d exp 64", cyc);
    else n_pass++;
  endtask

  task automatic test_stall();
    int cyc;
    load_block({32'h61626380, 448'h0, 32'h00000018});
    consume(64, 50, 1'b0, '0, cyc);
  endtask

  task automatic test_hold_valid();
    logic [511:0] b1, b2;
    int cyc;
    b1 = rand_block();
    b2 = rand_block();
    load_block(b1);
    consume(64, 100, 1'b1, b2, cyc);
    load_block(b2);
    consume(64, 100, 1'b0, '0, cyc);
  endtask

  task automatic test_flush();
    int cyc;
    load_block(rand_block());
    consume(20, 100, 1'b0, '0, cyc);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if ({out_valid, block_ready, round_index} !== {1'b0, 1'b1, 6'd0})
      $display("FAIL flush_run: got v=%b rdy=%b idx=%0d exp 0 1 0", out_valid, block_ready, round_index);
    else n_pass++;
    flush = 1'b1;
    block_valid = 1'b1;
    block_data = rand_block();
    @(negedge clk);
    flush = 1'b0;
    block_valid = 1'b0;
    n_checks++;
    if ({out_valid, block_ready} !== 2'b01)
      $display("FAIL flush_vs_load: got v/rdy=%b exp 01", {out_valid, block_ready});
    else n_pass++;
    load_block(rand_block());
    consume(64, 100, 1'b0, '0, cyc);
  endtask

  task automatic test_reset_mid();
    int cyc;
    load_block(rand_block());
    consume(40, 100, 1'b0, '0, cyc);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, block_ready, round_index, w_out} !== {1'b0, 1'b1, 6'd0, 32'd0})
      $display("FAIL reset_mid: got v=%b rdy=%b idx=%0d w=%h exp 0 1 0 00000000",
               out_valid, block_ready, round_index, w_out);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    load_block(rand_block());
    consume(64, 100, 1'b0, '0, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int pct;
    for (int b = 0; b < 100; b++) begin
      pct = (b < 30) ? 100 : int'($urandom_range(20, 100));
      load_block(rand_block());
      consume(64, pct, 1'b0, '0, cyc);
      if (pct == 100) begin
        n_checks++;
        if (cyc !== 64) $display("FAIL b2b_cycles[%0d]: got %0d exp 64", b, cyc);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_stall();
    test_hold_valid();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
